// File: rtl/mig_ui_arbiter.sv
// mig_ui_arbiter: round-robin multi-port front end for the MIG 7-series app_* interface,
// with a write-data FIFO and a read tag FIFO that routes in-order returns back to their port.
module mig_ui_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 27,
    parameter int DATA_W    = 128,
    parameter int WDF_DEPTH = 4,
    parameter int TAG_DEPTH = 8
) (
    input  logic                            ui_clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_rdy,
    input  logic [NUM_PORTS-1:0]            req_cmd,
    input  logic [NUM_PORTS*ADDR_W-1:0]     req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]     req_data,
    input  logic [NUM_PORTS*DATA_W/8-1:0]   req_mask,
    output logic [NUM_PORTS-1:0]            rsp_valid,
    output logic [DATA_W-1:0]               rsp_data,
    output logic [ADDR_W-1:0]               app_addr,
    output logic [2:0]                      app_cmd,
    output logic                            app_en,
    input  logic                            app_rdy,
    output logic [DATA_W-1:0]               app_wdf_data,
    output logic [DATA_W/8-1:0]             app_wdf_mask,
    output logic                            app_wdf_wren,
    output logic                            app_wdf_end,
    input  logic                            app_wdf_rdy,
    input  logic [DATA_W-1:0]               app_rd_data,
    input  logic                            app_rd_data_valid,
    input  logic                            init_calib_complete,
    output logic [$clog2(TAG_DEPTH):0]      outstanding,
    output logic                            err_unexpected_rd
);
    localparam int MW = DATA_W / 8;
    localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
    localparam int WA = $clog2(WDF_DEPTH);
    localparam int TA = $clog2(TAG_DEPTH);

    logic                 cmd_valid, cmd_rd, found, slot_free;
    logic [PW-1:0]        rr, gid;
    logic [PW:0]          idx;
    logic [NUM_PORTS-1:0] elig, grant;
    logic [DATA_W+MW-1:0] wdf_mem [WDF_DEPTH];
    logic [WA:0]          wdf_wp, wdf_rp;
    logic [PW-1:0]        tag_mem [TAG_DEPTH];
    logic [TA:0]          tag_wp, tag_rp;
    logic                 wdf_full, wdf_empty, tag_full, tag_empty;
    logic                 wdf_push, wdf_pop, tag_push, tag_pop;

    assign wdf_empty   = wdf_wp == wdf_rp;
    assign wdf_full    = (wdf_wp ^ wdf_rp) == {1'b1, {WA{1'b0}}};
    assign tag_empty   = tag_wp == tag_rp;
    assign tag_full    = (tag_wp ^ tag_rp) == {1'b1, {TA{1'b0}}};
    assign slot_free   = !cmd_valid || app_rdy;
    assign outstanding = tag_wp - tag_rp;

    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++)
            elig[k] = !rst && req_valid[k] && init_calib_complete && slot_free &&
                      (req_cmd[k] ? !tag_full : !wdf_full);
    end

    // First eligible port scanning upward from the priority pointer, wrapping at NUM_PORTS.
    always_comb begin
        grant = '0;
        gid   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = {1'b0, rr} + (PW+1)'(i);
            idx = idx >= (PW+1)'(NUM_PORTS) ? idx - (PW+1)'(NUM_PORTS) : idx;
            if (!found && elig[idx[PW-1:0]]) begin
                found                = 1'b1;
                grant[idx[PW-1:0]]   = 1'b1;
                gid                  = idx[PW-1:0];
            end
        end
    end

    assign req_rdy      = grant;
    assign wdf_push     = found && !req_cmd[gid];
    assign tag_push     = found && req_cmd[gid];
    assign wdf_pop      = app_wdf_wren && app_wdf_rdy;
    assign tag_pop      = app_rd_data_valid && !tag_empty;
    assign app_en       = cmd_valid;
    assign app_cmd      = {2'b00, cmd_rd};
    assign app_wdf_wren = !wdf_empty;
    assign app_wdf_end  = 1'b1;
    assign {app_wdf_data, app_wdf_mask} = wdf_mem[wdf_rp[WA-1:0]];

    always_ff @(posedge ui_clk) begin
        if (wdf_push)
            wdf_mem[wdf_wp[WA-1:0]] <= {req_data[gid*DATA_W +: DATA_W], req_mask[gid*MW +: MW]};
        if (tag_push)
            tag_mem[tag_wp[TA-1:0]] <= gid;
    end

    always_ff @(posedge ui_clk or posedge rst) begin
        if (rst) begin
            cmd_valid         <= 1'b0;
            cmd_rd            <= 1'b0;
            app_addr          <= '0;
            rr                <= '0;
            wdf_wp            <= '0;
            wdf_rp            <= '0;
            tag_wp            <= '0;
            tag_rp            <= '0;
            rsp_valid         <= '0;
            rsp_data          <= '0;
            err_unexpected_rd <= 1'b0;
        end else begin
            if (found) begin
                cmd_valid <= 1'b1;
                cmd_rd    <= req_cmd[gid];
                app_addr  <= req_addr[gid*ADDR_W +: ADDR_W];
                rr        <= gid == PW'(NUM_PORTS - 1) ? '0 : gid + 1'b1;
            end else if (app_rdy) begin
                cmd_valid <= 1'b0;
            end
            if (wdf_push)
                wdf_wp <= wdf_wp + 1'b1;
            if (wdf_pop)
                wdf_rp <= wdf_rp + 1'b1;
            if (tag_push)
                tag_wp <= tag_wp + 1'b1;
            if (tag_pop) begin
                tag_rp   <= tag_rp + 1'b1;
                rsp_data <= app_rd_data;
            end
            rsp_valid <= tag_pop ? NUM_PORTS'(1) << tag_mem[tag_rp[TA-1:0]] : '0;
            if (app_rd_data_valid && tag_empty)
                err_unexpected_rd <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mig_ui_arbiter.sv
// tb_mig_ui_arbiter: directed table plus hand sequences for calib gating, round-robin,
// write decoupling, read routing, tag-full blocking, unexpected reads and async reset.
module tb_mig_ui_arbiter;
    logic         ui_clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_valid, req_rdy, req_cmd, rsp_valid;
    logic [53:0]  req_addr;
    logic [255:0] req_data;
    logic [31:0]  req_mask;
    logic [127:0] rsp_data, app_wdf_data, app_rd_data;
    logic [26:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic [15:0]  app_wdf_mask;
    logic         app_rd_data_valid, init_calib_complete, err_unexpected_rd;
    logic [3:0]   outstanding;

    typedef struct {
        logic        calib;
        logic [1:0]  valid;
        logic [1:0]  cmd;
        logic        ardy;
        logic [1:0]  rdy;
        logic        en;
        logic [2:0]  acmd;
        logic [26:0] addr;
        logic        wren;
        logic [3:0]  outs;
    } vec_t;

    vec_t tbl[10];
    int   checks = 0;
    int   errors = 0;

    always #5 ui_clk = ~ui_clk;

    mig_ui_arbiter dut (
        .ui_clk(ui_clk), .rst(rst), .req_valid(req_valid), .req_rdy(req_rdy), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_rdy(app_rdy), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .init_calib_complete(init_calib_complete), .outstanding(outstanding),
        .err_unexpected_rd(err_unexpected_rd)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset;
        @(negedge ui_clk);
        rst = 1'b1;
        req_valid = 2'b00;
        req_cmd = 2'b00;
        app_rd_data_valid = 1'b0;
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        #1;
        chk("rst_rdy", req_rdy, 0);
        chk("rst_en", app_en, 0);
        chk("rst_wren", app_wdf_wren, 0);
        chk("rst_cmd", app_cmd, 0);
        chk("rst_addr", app_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err_unexpected_rd, 0);
        @(negedge ui_clk);
        rst = 1'b0;
    endtask

    initial begin
        req_valid = 2'b00;
        req_cmd = 2'b00;
        req_addr = {27'h200, 27'h100};
        req_data = {{4{32'h1111_2222}}, {4{32'hAAAA_5555}}};
        req_mask = 32'h00F0_000F;
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        app_rd_data = '0;
        app_rd_data_valid = 1'b0;
        init_calib_complete = 1'b0;

        tbl[0] = '{1, 2'b01, 2'b00, 1, 2'b01, 0, 3'd0, 27'h000, 0, 4'd0};
        tbl[1] = '{1, 2'b11, 2'b00, 1, 2'b10, 1, 3'd0, 27'h100, 1, 4'd0};
        tbl[2] = '{1, 2'b11, 2'b11, 1, 2'b01, 1, 3'd0, 27'h200, 1, 4'd0};
        tbl[3] = '{1, 2'b11, 2'b11, 1, 2'b10, 1, 3'd1, 27'h100, 0, 4'd1};
        tbl[4] = '{1, 2'b00, 2'b00, 1, 2'b00, 1, 3'd1, 27'h200, 0, 4'd2};
        tbl[5] = '{1, 2'b01, 2'b01, 0, 2'b01, 0, 3'd1, 27'h200, 0, 4'd2};
        tbl[6] = '{1, 2'b10, 2'b00, 0, 2'b00, 1, 3'd1, 27'h100, 0, 4'd3};
        tbl[7] = '{1, 2'b10, 2'b00, 1, 2'b10, 1, 3'd1, 27'h100, 0, 4'd3};
        tbl[8] = '{1, 2'b00, 2'b00, 1, 2'b00, 1, 3'd0, 27'h200, 1, 4'd3};
        tbl[9] = '{1, 2'b00, 2'b00, 1, 2'b00, 0, 3'd0, 27'h200, 0, 4'd3};

        do_reset();

        // Calibration gate
        init_calib_complete = 1'b0;
        req_valid = 2'b01;
        for (int i = 0; i < 20; i++) begin
            @(negedge ui_clk);
            #1;
            chk("calib_rdy", req_rdy, 0);
            chk("calib_en", app_en, 0);
        end
        @(negedge ui_clk);
        init_calib_complete = 1'b1;
        #1;
        chk("calib_grant", req_rdy, 2'b01);
        @(negedge ui_clk);
        req_valid = 2'b00;
        #1;
        chk("calib_en_next", app_en, 1);

        // Round-robin, slot stall and write/read interleave table
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge ui_clk);
            init_calib_complete = tbl[i].calib;
            req_valid = tbl[i].valid;
            req_cmd = tbl[i].cmd;
            app_rdy = tbl[i].ardy;
            #1;
            chk($sformatf("t%0d_rdy", i), req_rdy, tbl[i].rdy);
            chk($sformatf("t%0d_en", i), app_en, tbl[i].en);
            chk($sformatf("t%0d_cmd", i), app_cmd, tbl[i].acmd);
            chk($sformatf("t%0d_addr", i), app_addr, tbl[i].addr);
            chk($sformatf("t%0d_wren", i), app_wdf_wren, tbl[i].wren);
            chk($sformatf("t%0d_outs", i), outstanding, tbl[i].outs);
        end

        // Read routing: tags are 0,1,0
        @(negedge ui_clk);
        app_rd_data_valid = 1'b1;
        app_rd_data = {4{32'hD0D0_0000}};
        #1;
        chk("rd0_pre", rsp_valid, 0);
        @(negedge ui_clk);
        app_rd_data = {4{32'hD1D1_0001}};
        #1;
        chk("rd0_valid", rsp_valid, 2'b01);
        chk("rd0_data", rsp_data, {4{32'hD0D0_0000}});
        @(negedge ui_clk);
        app_rd_data = {4{32'hD2D2_0002}};
        #1;
        chk("rd1_valid", rsp_valid, 2'b10);
        chk("rd1_data", rsp_data, {4{32'hD1D1_0001}});
        @(negedge ui_clk);
        app_rd_data_valid = 1'b0;
        #1;
        chk("rd2_valid", rsp_valid, 2'b01);
        chk("rd2_data", rsp_data, {4{32'hD2D2_0002}});
        chk("rd_outs", outstanding, 0);
        @(negedge ui_clk);
        #1;
        chk("rd_idle", rsp_valid, 0);

        // Unexpected read data
        app_rd_data_valid = 1'b1;
        @(negedge ui_clk);
        app_rd_data_valid = 1'b0;
        #1;
        chk("err_set", err_unexpected_rd, 1);
        chk("err_no_rsp", rsp_valid, 0);
        chk("err_outs", outstanding, 0);

        // Write decoupling with WDF full
        do_reset();
        app_wdf_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ui_clk);
            req_valid = 2'b01;
            req_cmd = 2'b00;
            req_data[127:0] = {4{32'hC000_0000 + i}};
            req_mask[15:0] = 16'h0001 << i;
            #1;
            chk($sformatf("wdf_grant%0d", i), req_rdy, i < 4 ? 2'b01 : 2'b00);
        end
        @(negedge ui_clk);
        req_valid = 2'b11;
        req_cmd = 2'b10;
        #1;
        chk("wdf_read_pass", req_rdy, 2'b10);
        @(negedge ui_clk);
        req_valid = 2'b00;
        app_wdf_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge ui_clk);
            #1;
            chk($sformatf("drain%0d_wren", i), app_wdf_wren, 1);
            chk($sformatf("drain%0d_data", i), app_wdf_data, {4{32'hC000_0000 + i}});
            chk($sformatf("drain%0d_mask", i), app_wdf_mask, 16'h0001 << i);
            chk($sformatf("drain%0d_end", i), app_wdf_end, 1);
        end
        @(negedge ui_clk);
        #1;
        chk("drain_empty", app_wdf_wren, 0);

        // Tag FIFO full
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge ui_clk);
            req_valid = 2'b01;
            req_cmd = 2'b01;
            #1;
            chk($sformatf("tag_grant%0d", i), req_rdy, 2'b01);
        end
        @(negedge ui_clk);
        #1;
        chk("tag_full_outs", outstanding, 8);
        chk("tag_full_block", req_rdy, 0);
        @(negedge ui_clk);
        app_rd_data_valid = 1'b1;
        app_rd_data = {4{32'hBEEF_0001}};
        #1;
        chk("tag_pop_block", req_rdy, 0);
        @(negedge ui_clk);
        app_rd_data_valid = 1'b0;
        #1;
        chk("tag_after_outs", outstanding, 7);
        chk("tag_after_grant", req_rdy, 2'b01);
        chk("tag_rsp", rsp_valid, 2'b01);

        // Async reset mid-burst
        @(posedge ui_clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_en", app_en, 0);
        chk("arst_rdy", req_rdy, 0);
        chk("arst_outs", outstanding, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_rsp_data", rsp_data, 0);
        chk("arst_addr", app_addr, 0);
        chk("arst_wren", app_wdf_wren, 0);
        @(negedge ui_clk);
        req_valid = 2'b00;
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mig_ui_arbiter.md
# mig_ui_arbiter

Parametrised multi-port front end for the MIG 7-series user (app_*) interface. It round-robin arbitrates NUM_PORTS request channels into one command stage and decouples write data through a write-data FIFO. It tracks outstanding reads in a tag FIFO so each in-order read return is routed back to its originating port. It sits between the CPU/cache-side request ports and `mig_7series_0`, replacing the single-channel controller, and sustains one command per cycle.

## Interface
- NUM_PORTS, 2: request channels (1..8)
- ADDR_W, 27: app_addr width
- DATA_W, 128: data width; mask width is DATA_W/8
- WDF_DEPTH, 4: write-data FIFO entries (power of 2)
- TAG_DEPTH, 8: maximum outstanding reads (power of 2)

Ports:
- ui_clk  in  1  MIG user clock; sole clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_PORTS  per-port request valid
- req_rdy  out  NUM_PORTS  per-port accept; at most one bit high per cycle
- req_cmd  in  NUM_PORTS  per port: 0 = write, 1 = read
- req_addr  in  NUM_PORTS*ADDR_W  packed per-port address
- req_data  in  NUM_PORTS*DATA_W  packed per-port write data
- req_mask  in  NUM_PORTS*DATA_W/8  packed per-port byte mask; 1 = byte not written
- rsp_valid  out  NUM_PORTS  one-cycle read-return strobe, one-hot
- rsp_data  out  DATA_W  read data, shared by all ports
- app_addr  out  ADDR_W;  app_cmd  out  3;  app_en  out  1;  app_rdy  in  1
- app_wdf_data  out  DATA_W;  app_wdf_mask  out  DATA_W/8;  app_wdf_wren  out  1;  app_wdf_end  out  1;  app_wdf_rdy  in  1
- app_rd_data  in  DATA_W;  app_rd_data_valid  in  1
- init_calib_complete  in  1  MIG calibration done
- outstanding  out  $clog2(TAG_DEPTH)+1  reads issued but not yet returned
- err_unexpected_rd  out  1  sticky: read data arrived with the tag FIFO empty

## Operation
- Command stage: a one-entry register holding cmd_valid, app_addr, app_cmd and the port ID.
  - app_en = cmd_valid. app_cmd = {2'b00, cmd}.
  - The entry retires on app_en & app_rdy.
- Slot free = !cmd_valid | app_rdy. A new grant may load in the same cycle the old entry retires.
- Port k is eligible when all of the following hold:
  - req_valid[k], init_calib_complete, and slot free.
  - For a write: WDF FIFO not full.
  - For a read: tag FIFO not full.
- Arbitration is round-robin with a priority pointer rr (reset 0).
  - The first eligible port at or after rr (mod NUM_PORTS) is granted.
  - After a grant to port k, rr ← (k+1) mod NUM_PORTS. rr is unchanged when nothing is granted.
- req_rdy[k] = grant[k] (combinational). A transfer occurs when req_valid[k] & req_rdy[k].
- On a write grant, {req_data, req_mask} of port k is pushed into the WDF FIFO in the same cycle the command register loads.
  - app_wdf_wren = WDF not empty. app_wdf_data/app_wdf_mask = FIFO head. app_wdf_end = 1.
  - The head pops on app_wdf_wren & app_wdf_rdy.
  - Data may reach the MIG before or after its command; the MIG allows this and ordering is preserved.
- On a read grant, port ID k is pushed into the tag FIFO.
  - On app_rd_data_valid the tag head pops.
  - rsp_valid[tag] and rsp_data = app_rd_data are registered, giving one cycle latency. There is no backpressure; ports must accept.
- app_rd_data_valid with the tag FIFO empty: set err_unexpected_rd, assert no rsp_valid, hold tag state.
- outstanding = tag FIFO count.
  - Simultaneous push and pop leaves the count unchanged.
  - A pop at TAG_DEPTH frees the slot combinationally only in the next cycle. Full blocks the grant even if a pop is occurring.
- WDF full and a write not yet drained: writes stall; reads from other ports may still be granted.

## Timing
- Reset values: req_rdy 0, app_en 0, app_wdf_wren 0, app_cmd 0, app_addr 0, rsp_valid 0, rsp_data 0, outstanding 0, err_unexpected_rd 0, rr 0, both FIFOs empty.
- Reset mid-operation clears all in-flight state immediately. Reset is used together with the MIG reset; any requests in flight are lost.
- Grant in cycle N gives app_en = 1 in cycle N+1. A write grant in cycle N gives app_wdf_wren = 1 earliest in cycle N+1.
- Throughput: with app_rdy held high, one command per cycle with no bubble, back-to-back.
- app_en, app_addr and app_cmd hold stable while app_rdy is low.
- Before init_calib_complete, all req_rdy are 0.
- Read return: app_rd_data_valid in cycle M gives rsp_valid in cycle M+1.
- FIFO pointers wrap modulo depth, using one extra bit to distinguish full from empty.

## Test plan
- Calib gate: req_valid[0]=1 with calib=0 for 20 cycles → req_rdy=0 and app_en=0; after calib rises → app_en the next cycle following the grant.
- Round-robin: both ports valid continuously with app_rdy=1 → grants alternate 0,1,0,1…, app_en high every cycle, no bubbles.
- Write decoupling: app_wdf_rdy=0 with 4 writes issued (WDF_DEPTH=4) → 5th write stalls while a read on port 1 is still granted; app_wdf_rdy=1 → 4 beats drain with masks intact.
- Read routing: port 0 reads A, port 1 reads B, port 0 reads C; returns D0,D1,D2 → rsp_valid one-hot to 0,1,0 with matching data, one cycle after each valid.
- Tag full: 8 reads outstanding → outstanding=8 and further reads blocked; one return → outstanding=7 and a read is granted the next cycle.
- Error/reset: app_rd_data_valid with empty tags → err_unexpected_rd=1 and no rsp_valid; async rst mid-burst → all outputs take reset values immediately.
